// File: rtl/prbs31_pkg.sv
// PRBS31 checker shared definitions.
// Polynomial x^31 + x^28 + 1, same taps as the generator.
package prbs31_pkg;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;
  localparam int FILL_W   = $clog2(PRBS_LEN + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic logic prbs_next(
    input logic [PRBS_LEN-1:0] sh
  );
    return sh[TAP_A] ^ sh[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module prbs31_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear, else increment until all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: hunt for sync, then free-run
// the reference, count errors and bits, drop lock on bursts.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOCK_COUNT  = 64,
  parameter int LOSS_ERRS   = 8,
  parameter int LOSS_WINDOW = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             inv,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             lol_sticky
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(LOSS_WINDOW);
  localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_MAX =
    FILL_W'(PRBS_LEN);
  localparam logic [MATCH_W-1:0] MATCH_LAST =
    MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WERR_W-1:0]  WERR_LIM =
    WERR_W'(LOSS_ERRS);

  state_e               state_q, state_d;
  logic [PRBS_LEN-1:0]  sh_q, sh_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [WERR_W-1:0]    werr_q, werr_d;
  logic [WERR_W-1:0]    werr_inc;
  logic                 err_q, err_d;
  logic                 lol_q, lol_d;
  logic                 r, e, hit, mis;
  logic                 ecnt_en, bcnt_en;

  assign r   = din ^ inv;
  assign e   = prbs_next(sh_q);
  assign hit = (r == e) && (sh_q != '0);
  assign mis = (r != e);

  assign werr_inc = werr_q + {{(WERR_W-1){1'b0}}, mis};

  // hunt/lock sequencing and reference update
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    lol_d   = lol_q & ~clr;
    ecnt_en = 1'b0;
    bcnt_en = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          sh_d = {sh_q[PRBS_LEN-2:0], r};
          if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FILL_W'(1);
          end else if (hit) begin
            if (match_q == MATCH_LAST) begin
              state_d = LOCKED;
              match_d = '0;
              win_d   = '0;
              werr_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          sh_d    = {sh_q[PRBS_LEN-2:0], e};
          err_d   = mis;
          ecnt_en = mis;
          bcnt_en = 1'b1;
          win_d   = win_q + WIN_W'(1);
          if (werr_inc == WERR_LIM) begin
            state_d = HUNT;
            fill_d  = '0;
            match_d = '0;
            werr_d  = werr_inc;
            lol_d   = 1'b1;
          end else if (win_q == '1) begin
            werr_d = '0;
          end else begin
            werr_d = werr_inc;
          end
        end
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      sh_q    <= '0;
      fill_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= 1'b0;
      lol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      lol_q   <= lol_d;
    end
  end

  prbs31_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ecnt_en),
    .clr_i (clr),
    .cnt_o (err_count)
  );

  prbs31_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (bcnt_en),
    .clr_i (clr),
    .cnt_o (bit_count)
  );

  assign locked     = (state_q == LOCKED);
  assign err        = err_q;
  assign lol_sticky = lol_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: bit-history reference model,
// directed lock/loss scenarios and a randomized soak.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        inv = 1'b0;
  logic        clr = 1'b0;
  logic        locked, err, lol_sticky;
  logic [15:0] err_count, bit_count;
  logic        b_locked, b_err, b_lol;
  logic [3:0]  b_ec, b_bc;

  int checks = 0;
  int errors = 0;
  bit cur_inv = 1'b0;

  always #5 clk = ~clk;

  prbs31_checker u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .inv        (inv),
    .clr        (clr),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .bit_count  (bit_count),
    .lol_sticky (lol_sticky)
  );

  prbs31_checker #(
    .CNT_W (4)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .inv        (inv),
    .clr        (clr),
    .locked     (b_locked),
    .err        (b_err),
    .err_count  (b_ec),
    .bit_count  (b_bc),
    .lol_sticky (b_lol)
  );

  task automatic chk(input string n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t",
               n, got, exp, $time);
    end
  endtask

  // generator: b[n] = b[n-31] ^ b[n-28], seeded with 1
  bit gq[$];
  function automatic bit gen();
    bit nb;
    nb = gq[0] ^ gq[3];
    gq.push_back(nb);
    void'(gq.pop_front());
    return nb;
  endfunction

  // reference model: mh holds the last 31 reference bits,
  // mh[0] oldest (31 bits ago), mh[3] is 28 bits ago
  bit mh[$];
  bit m_lock, m_err, m_lol;
  int m_fill, m_match, m_wpos, m_werr, m_ec, m_bc;

  task automatic m_rst();
    mh.delete();
    for (int i = 0; i < 31; i++) mh.push_back(1'b0);
    m_lock = 0; m_err = 0; m_lol = 0;
    m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
    m_ec = 0; m_bc = 0;
  endtask

  task automatic m_step();
    bit mr, me, mmis;
    int ones;
    m_err = 0;
    if (clr) begin
      m_ec = 0; m_bc = 0; m_lol = 0;
    end
    if (din_valid) begin
      mr = din ^ inv;
      me = mh[0] ^ mh[3];
      if (!m_lock) begin
        ones = 0;
        foreach (mh[i]) ones += int'(mh[i]);
        if (m_fill < 31) m_fill++;
        else if (mr == me && ones != 0) begin
          m_match++;
          if (m_match == 64) begin
            m_lock = 1; m_match = 0;
            m_wpos = 0; m_werr = 0;
          end
        end else m_match = 0;
        mh.push_back(mr);
      end else begin
        mmis = (mr != me);
        m_err = mmis;
        if (!clr) begin
          if (m_bc < 65535) m_bc++;
          if (mmis && m_ec < 65535) m_ec++;
        end
        m_werr += int'(mmis);
        m_wpos++;
        if (m_werr == 8) begin
          m_lock = 0; m_fill = 0; m_match = 0; m_lol = 1;
        end else if (m_wpos == 1024) begin
          m_wpos = 0; m_werr = 0;
        end
        mh.push_back(me);
      end
      void'(mh.pop_front());
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_rst();
    else m_step();
  end

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("locked", locked, m_lock);
      chk("err", err, m_err);
      chk("err_count", err_count, m_ec);
      chk("bit_count", bit_count, m_bc);
      chk("lol_sticky", lol_sticky, m_lol);
      chk("b_locked", b_locked, m_lock);
      chk("b_err_count", b_ec, (m_ec > 15) ? 15 : m_ec);
      chk("b_bit_count", b_bc, (m_bc > 15) ? 15 : m_bc);
    end
  end

  task automatic step(input bit d, input bit v, input bit c);
    @(negedge clk);
    din = d;
    din_valid = v;
    clr = c;
    inv = cur_inv;
  endtask

  task automatic step_bit(input bit flip, input bit c);
    bit g;
    g = gen();
    step(g ^ flip ^ cur_inv, 1'b1, c);
  endtask

  task automatic step_idle();
    step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic lock_seq(input int done);
    repeat (95 - done) step_bit(1'b0, 1'b0);
    chk("pre_lock", locked, 0);
    step_bit(1'b0, 1'b0);
    chk("lock", locked, 1);
  endtask

  task automatic zero_checks(input string n);
    chk({n, "_locked"}, locked, 0);
    chk({n, "_err"}, err, 0);
    chk({n, "_err_count"}, err_count, 0);
    chk({n, "_bit_count"}, bit_count, 0);
    chk({n, "_lol"}, lol_sticky, 0);
  endtask

  task automatic do_reset(input string n);
    @(negedge clk);
    din_valid = 1'b0;
    clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 zero_checks(n);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 31; i++) gq.push_back(i == 0);
    m_rst();
    #3 zero_checks("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    lock_seq(0);
    repeat (100) step_bit(1'b0, 1'b0);
    chk("lock_bit_count", bit_count, 100);
    chk("lock_err_count", err_count, 0);
    chk("sat_bit_count", b_bc, 15);

    step_bit(1'b1, 1'b0);
    step_bit(1'b0, 1'b0);
    chk("single_err", err, 1);
    chk("single_count", err_count, 1);
    step_bit(1'b0, 1'b0);
    chk("single_err_gone", err, 0);

    repeat (7) begin
      repeat (19) step_bit(1'b0, 1'b0);
      step_bit(1'b1, 1'b0);
    end
    step_bit(1'b0, 1'b0);
    chk("loss_locked", locked, 0);
    chk("loss_lol", lol_sticky, 1);
    chk("loss_err_count", err_count, 8);
    lock_seq(1);

    repeat (8) begin
      repeat (19) step_bit(1'b0, 1'b0);
      step_bit(1'b1, 1'b0);
    end
    step_bit(1'b0, 1'b0);
    chk("loss2_locked", locked, 0);
    chk("loss2_err_count", err_count, 16);
    chk("sat_err_count", b_ec, 15);
    lock_seq(1);

    repeat (10) step_bit(1'b0, 1'b0);
    step_bit(1'b1, 1'b1);
    step_bit(1'b0, 1'b0);
    chk("clr_err_pulse", err, 1);
    chk("clr_err_count", err_count, 0);
    chk("clr_bit_count", bit_count, 0);
    chk("clr_lol", lol_sticky, 0);
    repeat (20) step_bit(1'b0, 1'b0);

    do_reset("midlock");

    repeat (94) begin
      step_bit(1'b0, 1'b0);
      step_idle();
    end
    step_bit(1'b0, 1'b0);
    chk("toggle_pre_lock", locked, 0);
    step_idle();
    chk("toggle_lock", locked, 1);

    do_reset("stuck_rst");
    seen = 1'b0;
    repeat (500) begin
      step(1'b0, 1'b1, 1'b0);
      seen |= locked;
    end
    chk("stuck_never_locks", seen, 0);

    do_reset("inv_rst");
    cur_inv = 1'b1;
    lock_seq(0);
    repeat (50) step_bit(1'b0, 1'b0);
    chk("inv_err_count", err_count, 0);
    cur_inv = 1'b0;

    do_reset("rand_rst");
    repeat (20000) begin
      if ($urandom_range(0, 3) != 0) begin
        step_bit(1'($urandom_range(0, 149) == 0),
                 1'($urandom_range(0, 499) == 0));
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0,
             1'($urandom_range(0, 499) == 0));
      end
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
Receive-side checker for the PRBS31 stream (x^31 + x^28 + 1) produced by our generator block. It synchronises to an incoming serial bit stream and locks once enough consecutive bits match. After lock it free-runs its own reference, counts bit errors and received bits, and drops lock when the error density is too high.
It sits behind a serial input pin or a loopback path and feeds status and counter outputs to the top-level wrapper.

Parameters:
LOCK_COUNT, 64, consecutive matching bits needed in HUNT before LOCKED is entered
LOSS_ERRS, 8, errors within one window that force a return to HUNT
LOSS_WINDOW, 1024, window length in valid bits (power of two)
CNT_W, 16, width of err_count and bit_count

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  reset, asynchronous, active-low
din  in  1  received serial bit
din_valid  in  1  din is sampled only in cycles where this is 1
inv  in  1  when 1, din is inverted before use (checks the complementary output)
clr  in  1  synchronous clear of err_count, bit_count and lol_sticky
locked  out  1  1 while in LOCKED
err  out  1  one-cycle pulse: the previous valid bit mismatched while LOCKED
err_count  out  CNT_W  errors counted while LOCKED, saturating at all-ones
bit_count  out  CNT_W  valid bits counted while LOCKED, saturating at all-ones
lol_sticky  out  1  set on every LOCKED->HUNT transition, cleared by clr

Behaviour:
- Reset (rst_n=0, asynchronous) sets state HUNT and clears sh[30:0], fill_cnt, match_cnt, win_cnt, win_err, err, err_count, bit_count and lol_sticky. Outputs are low or zero.
- Let r = din ^ inv. When din_valid=1, expected e = sh[27] ^ sh[30], where sh[0] is the newest bit and sh[30] is the bit 31 valid bits earlier.
- Nothing changes in cycles where din_valid=0, except that clr still applies.

HUNT state:
- Every valid bit shifts r in: sh <= {sh[29:0], r}.
- fill_cnt counts from 0 to 31 and saturates. No compare is made until fill_cnt reaches 31.
- A compare is a match only when r == e and sh != 0. The all-zero register always counts as a mismatch, so a stuck-at-0 input never locks.
- A match increments match_cnt. A mismatch clears match_cnt.
- When the compare that takes match_cnt to LOCK_COUNT occurs, the next state is LOCKED. locked rises in the cycle after that bit.
- On entry to LOCKED, win_cnt and win_err are cleared.

LOCKED state:
- Every valid bit shifts e in, not r: sh <= {sh[29:0], e}. The reference free-runs, so a line error costs exactly one error.
- If r != e:
  - err is 1 in the next cycle; otherwise err is 0.
  - err_count increments, saturating.
  - win_err increments.
- bit_count increments on every valid bit, saturating.
- win_cnt counts valid bits modulo LOSS_WINDOW. When it wraps, win_err is cleared.
- If win_err reaches LOSS_ERRS (the bit that makes it so counts), the design goes to HUNT in the next cycle:
  - locked falls.
  - lol_sticky is set.
  - fill_cnt and match_cnt are cleared, so a full 31-bit refill is required.

Boundary conditions:
- If the threshold is reached on the same bit as the window wrap, the threshold wins and lock is lost.
- clr in the same cycle as an error or bit increment: clr wins, so the counters become 0. The err pulse is still produced.
- clr in the same cycle as a loss of lock: lol_sticky ends at 1, because the set wins over the clear.
- Counters are frozen in HUNT and hold their values across relock.
- Asserting rst_n low mid-stream returns everything to reset values immediately, asynchronously.

Decomposition:
- Shared package holds:
  - PRBS31 constants: register length 31, taps 30 and 27 (the same taps the generator uses).
  - State encoding: HUNT=0, LOCKED=1.
- One sub-module, prbs31_sat_counter (CNT_W, increment enable, synchronous clear, saturate at all-ones), instantiated for err_count and bit_count.

Test Plan:
- Clean stream: generator seeded 31'd1 drives din at one bit per cycle, din_valid=1, inv=0. Expected:
  - the first 31 bits fill the register;
  - locked rises the cycle after the 95th valid bit (31 fill bits plus 64 matches);
  - err_count stays 0 and bit_count increments once per cycle.
- Single error: once locked, flip one bit. Expected: one err pulse one cycle later, err_count=1, and no further errors.
- Loss of lock: flip 8 bits within 1024 bits. Expected:
  - after the 8th flip, locked=0 and lol_sticky=1;
  - relock within 95 further clean bits;
  - err_count=8.
- Stuck input and inversion:
  - din held at 0 for 500 bits: locked never asserts.
  - the complementary generator output with inv=1: locks exactly as in the clean-stream case.
- Corner cases:
  - din_valid toggled every other cycle: lock happens after 95 valid bits (about 190 cycles).
  - clr asserted in the same cycle as an error: err_count=0 and the err pulse is still seen.
  - Saturation with CNT_W=4: err_count holds at 15.
  - rst_n pulsed low mid-lock: all outputs go to 0 immediately.
